// File: rtl/memory_ctrl_pkg.sv
// Shared types and lane helpers for the memory-stage data-bus controller.
package pipes;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {IDLE, REQ, DONE, ABORT} memctl_state_t;

  typedef logic [1:0] mem_size_t;

  typedef struct packed {
    logic              store;
    mem_size_t         size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_op_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    mem_size_t         size;
    logic [7:0]        strobe;
    logic [DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;

  // Byte-lane enables for a store; lanes past byte 7 fall off the top.
  function automatic logic [7:0] store_strobe(mem_size_t size, logic [2:0] off);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic logic misaligned(mem_size_t size, logic [2:0] off);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/memory_ctrl_if.sv
// Pipeline and data-bus signals of the memory-stage controller.
interface memory_ctrl_if;
  import pipes::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  mem_size_t         req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              flush;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_misalign;
  logic              stall;
  dbus_req_t         dreq;
  dbus_resp_t        dresp;

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
           flush, resp_ready, dresp,
    input  req_ready, resp_valid, resp_rdata, resp_misalign, stall, dreq
  );

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
           flush, resp_ready, dresp,
    output req_ready, resp_valid, resp_rdata, resp_misalign, stall, dreq
  );

endinterface

// File: rtl/memory_ctrl_extract.sv
// Load-data lane extraction: shift the addressed bytes down and extend.
module memctl_extract
  import pipes::*;
(
  input  logic [2:0]        i_off,
  input  mem_size_t         i_size,
  input  logic              i_uns,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_result
);

  logic [DATA_W-1:0] w_shift;

  assign w_shift = i_data >> {i_off, 3'b000};

  always_comb begin
    o_result = w_shift;
    case (i_size)
      2'd0:    o_result = i_uns ? {56'd0, w_shift[7:0]}  : {{56{w_shift[7]}},  w_shift[7:0]};
      2'd1:    o_result = i_uns ? {48'd0, w_shift[15:0]} : {{48{w_shift[15]}}, w_shift[15:0]};
      2'd2:    o_result = i_uns ? {32'd0, w_shift[31:0]} : {{32{w_shift[31]}}, w_shift[31:0]};
      default: o_result = w_shift;
    endcase
  end

endmodule

// File: rtl/memory_ctrl.sv
// Memory-stage load/store sequencer owning the data bus request.
// Optional misalignment trap: MEMCTL_MISALIGN_CHECK_EN.
module memory_ctrl
  import pipes::*;
(
  input  logic          clk,
  input  logic          reset,
  memory_ctrl_if.slave  bus
);

  memctl_state_t     r_state, w_state_nxt;
  dbus_req_t         r_dreq, w_dreq_nxt, w_new_req;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt, w_ext;
  logic              r_misalign, w_misalign_nxt;
  logic              r_store, r_uns;
  mem_size_t         r_size;
  logic [2:0]        r_off;
  mem_op_t           w_in;
  logic              w_accept, w_go;

  assign w_in = '{store: bus.req_store, size: bus.req_size, uns: bus.req_unsigned,
                  addr: bus.req_addr, wdata: bus.req_wdata};

  assign bus.req_ready = ((r_state == IDLE) || ((r_state == DONE) && bus.resp_ready)) && !bus.flush;
  assign w_accept      = bus.req_valid && bus.req_ready;

  // Bus request for the incoming op, lanes placed by the low address bits.
  always_comb begin
    w_new_req        = '0;
    w_new_req.valid  = 1'b1;
    w_new_req.addr   = {w_in.addr[ADDR_W-1:3], 3'b000};
    w_new_req.size   = w_in.size;
    w_new_req.strobe = w_in.store ? store_strobe(w_in.size, w_in.addr[2:0]) : 8'h00;
    w_new_req.data   = w_in.store ? (w_in.wdata << {w_in.addr[2:0], 3'b000}) : '0;
  end

  memctl_extract u_extract (
    .i_off    (r_off),
    .i_size   (r_size),
    .i_uns    (r_uns),
    .i_data   (bus.dresp.data),
    .o_result (w_ext)
  );

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_dreq_nxt     = r_dreq;
    w_rdata_nxt    = r_rdata;
    w_misalign_nxt = r_misalign;
    w_go           = 1'b0;
    case (r_state)
      IDLE: w_go = w_accept;
      REQ: begin
        if (bus.dresp.data_ok) begin
          w_dreq_nxt = '0;
          if (bus.flush) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt    = DONE;
            w_rdata_nxt    = r_store ? '0 : w_ext;
            w_misalign_nxt = 1'b0;
          end
        end else if (bus.flush) begin
          w_state_nxt = ABORT;
        end
      end
      ABORT: begin
        if (bus.dresp.data_ok) begin
          w_dreq_nxt  = '0;
          w_state_nxt = IDLE;
        end
      end
      DONE: begin
        if (w_accept) w_go = 1'b1;
        else if (bus.flush || bus.resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_go) begin
`ifdef MEMCTL_MISALIGN_CHECK_EN
      if (misaligned(w_in.size, w_in.addr[2:0])) begin
        w_state_nxt    = DONE;
        w_dreq_nxt     = '0;
        w_rdata_nxt    = '0;
        w_misalign_nxt = 1'b1;
      end else
`endif
      begin
        w_state_nxt    = REQ;
        w_dreq_nxt     = w_new_req;
        w_misalign_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_dreq     <= '0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
      r_store    <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= 2'd0;
      r_off      <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_dreq     <= w_dreq_nxt;
      r_rdata    <= w_rdata_nxt;
      r_misalign <= w_misalign_nxt;
      if (w_go) begin
        r_store <= w_in.store;
        r_uns   <= w_in.uns;
        r_size  <= w_in.size;
        r_off   <= w_in.addr[2:0];
      end
    end
  end

  assign bus.dreq          = r_dreq;
  assign bus.resp_valid    = (r_state == DONE);
  assign bus.resp_rdata    = r_rdata;
  assign bus.resp_misalign = r_misalign;
  assign bus.stall         = (r_state == REQ) || (r_state == ABORT);

endmodule

// File: doc/memory_ctrl.md
# memory_ctrl

Sequencing controller for the memory stage's data-bus port: it accepts one load/store at a time from the pipeline, drives `dreq` with a stable request until `dresp.data_ok`, and returns aligned, extended load data. It owns byte-strobe and write-data lane placement and load-data extraction, and stalls the pipeline while a transaction is outstanding. It sits between `execute_data_t` decode and `memory_data_t` writeback in the memory stage and is the only driver of `dreq`.

## Interface
- `ADDR_W`, 64, address width
- `DATA_W`, 64, bus data width; fixed at 64, 8 byte lanes
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low
- `req_valid`  in  1  pipeline presents a memory op
- `req_ready`  out  1  op accepted this cycle when `req_valid && req_ready`
- `req_store`  in  1  1 = store, 0 = load
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- `req_unsigned`  in  1  zero-extend load (ignored for store and dword)
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  64  store data, right-aligned
- `flush`  in  1  discard in-flight and pending results
- `resp_valid`  out  1  result available
- `resp_ready`  in  1  pipeline consumes result
- `resp_rdata`  out  64  extended load data; 0 for stores
- `resp_misalign`  out  1  misaligned-access flag (see Configuration)
- `stall`  out  1  high in REQ and ABORT
- `dreq`  out  `dbus_req_t`  bus request
- `dresp`  in  `dbus_resp_t`  bus response

## Operation
- States: IDLE, REQ, DONE, ABORT. Reset → IDLE; all outputs 0, `dreq` all fields 0.
- `req_ready` = (IDLE || (DONE && resp_ready)) && !flush.
- Accept: latch op, go REQ. REQ drives `dreq.valid=1`, `addr={addr[63:3],3'b0}`, `size` per `req_size`, `strobe` and `data` below; held bit-stable until `data_ok`.
- Store strobe: byte 8'h01, half 8'h03, word 8'h0F, dword 8'hFF, shifted left by `addr[2:0]`; data = `req_wdata << (addr[2:0]*8)`. Load strobe = 0.
- REQ + `data_ok`: capture `dresp.data`, go DONE. Load extraction: shift right by `addr[2:0]*8`, keep 8/16/32/64 bits, sign- or zero-extend per `req_unsigned`.
- DONE: `resp_valid=1`, outputs stable until `resp_ready`. `resp_ready && req_valid` → back-to-back accept into REQ; `resp_ready` alone → IDLE.
- Flush: IDLE → no accept. DONE → IDLE, result dropped, new request ignored. REQ without `data_ok` → ABORT (bus request still held to completion). REQ with `data_ok` same cycle → IDLE. ABORT + `data_ok` → IDLE, data dropped, no `resp_valid`. Flush in ABORT: no effect.
- Reset mid-transaction: immediate IDLE, `dreq.valid` drops asynchronously.

## Timing
- All outputs registered or decoded from registered state; no combinational path from `dresp` to `dreq`.
- Minimum latency: accept at edge N, `dreq.valid` cycle N+1, `data_ok` in N+1 → `resp_valid` cycle N+2.
- Each extra wait cycle on `data_ok` adds one cycle; `stall` high from N+1 until the `data_ok` cycle inclusive.
- Sustained throughput with zero-wait bus and `resp_ready=1`: one op per 2 cycles.

## Configuration
- `MEMCTL_MISALIGN_CHECK_EN` defined: op whose `addr` is not a multiple of 1<<`req_size` issues no bus request; goes IDLE → DONE next cycle with `resp_misalign=1`, `resp_rdata=0`.
- Not defined: no check, `resp_misalign` tied 0; misaligned ops issue with strobe truncated to 8 bits, data undefined.

## Structure
- `pipes` package: `memctl_state_t` enum (IDLE/REQ/DONE/ABORT), `mem_size_t` (2-bit), `mem_op_t` struct {store, size, unsigned, addr, wdata}.
- Sub-module `memctl_extract`: combinational load shift/extend (addr[2:0], size, unsigned, 64-bit data → 64-bit result).

## Test plan
- Load byte, addr 0x1003, bus data 0x0000_0000_8000_0000, signed → `resp_rdata`=0xFFFF_FFFF_FFFF_FF80; unsigned → 0x80.
- Store half, addr 0x2006, wdata 0xBEEF → `dreq.strobe`=8'hC0, `dreq.data`=0xBEEF_0000_0000_0000, `dreq.addr`=0x2000.
- `data_ok` delayed 3 cycles → `dreq` fields constant for 4 cycles, `stall` high 4 cycles, `resp_valid` on cycle after `data_ok`.
- Flush in REQ cycle 2, `data_ok` cycle 4 → `dreq.valid` held through cycle 4, no `resp_valid`, `req_ready` high cycle 5.
- Back-to-back: DONE with `resp_ready=1`, `req_valid=1` → new `dreq.valid` next cycle, no IDLE cycle.
- With macro: load word addr 0x3002 → no `dreq.valid`, `resp_valid` + `resp_misalign`=1 two cycles after accept... i.e. next cycle after accept.
